// File: rtl/ram_readback_module.sv
// Sweeps a single-port RAM, realigns the one-cycle-late read data with its address,
// and streams address/data pairs through a 2-entry skid buffer while summing a checksum.
module ram_readback_module #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_sig,
    output logic              done_sig,
    output logic              read_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] checksum
);

    localparam int               CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t              r_state;
    logic                r_done;
    logic [CNT_W-1:0]    r_issued;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_checksum;

    logic                r_inflight;
    logic [ADDR_W-1:0]   r_cap_addr;
    logic [DATA_W-1:0]   r_fifo_data [2];
    logic [ADDR_W-1:0]   r_fifo_addr [2];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_occ;

    logic                w_pop;
    logic                w_push;
    logic                w_read;
    logic                w_drained;
    logic [2:0]          w_pending;

    assign w_pop  = out_valid && out_ready;
    assign w_push = r_inflight;

    // Slots the buffer will hold after this edge if no new read is issued; a read
    // is only launched when it is guaranteed a slot, so the buffer can never overflow.
    assign w_pending = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
    assign w_read    = (r_state == READ) && (r_issued < CNT_DEPTH) && (w_pending < 3'd2);

    assign w_drained = !r_inflight && ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_done     <= 1'b0;
            r_issued   <= '0;
            r_ram_addr <= '0;
            r_checksum <= '0;
        end else begin
            if (w_pop) begin
                r_checksum <= r_checksum + out_data;
            end
            case (r_state)
                IDLE: begin
                    if (start_sig) begin
                        r_state    <= READ;
                        r_issued   <= '0;
                        r_ram_addr <= '0;
                        r_checksum <= '0;
                    end
                end
                READ: begin
                    if (w_read) begin
                        r_issued <= r_issued + CNT_W'(1);
                        // The address saturates at the last word instead of wrapping.
                        if (r_issued != CNT_LAST) begin
                            r_ram_addr <= r_ram_addr + ADDR_W'(1);
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start_sig) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the two buffer entries are reset because out_data/out_addr expose the
    // head directly and must read zero out of reset; a larger memory would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight     <= 1'b0;
            r_cap_addr     <= '0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_addr[0] <= '0;
            r_fifo_addr[1] <= '0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_occ          <= 2'd0;
        end else begin
            r_inflight <= w_read;
            if (w_read) begin
                r_cap_addr <= r_ram_addr;
            end
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= ram_data;
                r_fifo_addr[r_wr_ptr] <= r_cap_addr;
                r_wr_ptr              <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign done_sig  = r_done;
    assign read_en   = w_read;
    assign ram_addr  = r_ram_addr;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_fifo_data[r_rd_ptr];
    assign out_addr  = r_fifo_addr[r_rd_ptr];
    assign checksum  = r_checksum;

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_occ == 2'd2)));

endmodule

// File: doc/ram_readback_module.md
Name: ram_readback_module

Overview:
- Read-side counterpart of the ROM-to-RAM copy controller.
- On start_sig it sweeps the 16x8 single-port RAM from address 0 to DEPTH-1 and realigns the one-cycle-late ram_data with its address.
- It streams each address/data pair to a downstream consumer through a valid/ready port with a 2-entry skid buffer, and accumulates an 8-bit checksum.
- It raises done_sig when the last word is accepted. It sits between the RAM read port and the verification/display logic.

Parameters:
- ADDR_W, 4, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 16, number of words read per run; 1 <= DEPTH <= 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_sig  in  1  level request to run one sweep; honoured only in IDLE.
- done_sig  out  1  run complete; held while start_sig is high (see DONE).
- read_en  out  1  RAM read strobe.
- ram_addr  out  ADDR_W  RAM read address, valid with read_en.
- ram_data  in  DATA_W  RAM read data, valid exactly 1 cycle after read_en.
- out_valid  out  1  out_data/out_addr valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  DATA_W  word read.
- out_addr  out  ADDR_W  address the word came from.
- checksum  out  DATA_W  sum of accepted out_data mod 2^DATA_W; final when done_sig=1.

Behaviour:
- Reset (async, rst_n=0): state IDLE. done_sig, read_en, out_valid = 0. ram_addr, out_data, out_addr, checksum = 0. Issue counter, in-flight flag and buffer occupancy are cleared. Reset mid-run abandons the run; no partial done_sig is produced.
- FSM:
  - IDLE: start_sig=1 -> READ. The checksum and counters clear on the same edge.
  - READ: issue reads until DEPTH issued; -> DRAIN when the last read is issued.
  - DRAIN: wait until in-flight=0, buffer empty, and the last word accepted; -> DONE.
  - DONE: done_sig=1. If start_sig=0 -> IDLE; otherwise stay (done_sig held). A pulse-style start that is already low yields a 1-cycle done_sig.
- Read issue (READ only):
  - read_en=1 iff issued<DEPTH and (occ + inflight - pop) < 2, where pop = out_valid && out_ready this cycle.
  - This is a combinational path from out_ready to read_en by design.
  - ram_addr = issue count; it increments after each issued read and is registered-stable when read_en=0.
- Data alignment:
  - inflight and the captured address are registered from read_en/ram_addr (1-cycle bypass).
  - On the next cycle, ram_data and the delayed address are pushed into the 2-entry FIFO.
  - Occupancy can never exceed 2; an overflow is a design error (assertion).
- Output:
  - out_valid = FIFO non-empty; out_data/out_addr = FIFO head.
  - Head is stable while out_valid && !out_ready.
  - Push and pop in the same cycle are legal at any occupancy 0..2.
- Checksum: on each pop, checksum <= checksum + out_data, wrapping mod 2^DATA_W. Held through DONE and IDLE until the next start.
- Latency: with start_sig seen high in IDLE at cycle t:
  - first read_en at t+1;
  - first out_valid at t+3;
  - with out_ready=1 continuously, one word per cycle through t+2+DEPTH, and done_sig first high at t+3+DEPTH.
- Ordering: words leave strictly in address order 0..DEPTH-1, each exactly once.
- start_sig in READ/DRAIN/DONE: ignored; no restart and no counter disturbance.
- Address wrap: the issue counter stops at DEPTH. With DEPTH=2^ADDR_W, ram_addr never wraps beyond DEPTH-1 within a run.

Test Plan:
- Full throughput: RAM mem[i]=3i+1, start at t, out_ready=1 -> read_en t+1..t+16; out_valid t+3..t+18 with out_addr 0..15, out_data 1,4,...,46; done_sig at t+19; checksum=0x78.
- Stall from start: out_ready=0 for 12 cycles -> exactly 2 reads (addr 0,1), out_valid=1 with out_data=1/out_addr=0 held stable. Then out_ready=1 -> remaining 14 words in order, checksum=0x78.
- Random out_ready (50%, 500 runs, random RAM contents) -> scoreboard: no loss or duplication, address order preserved, occ<=2 always, checksum = model sum mod 256.
- Held start: start_sig high for 40 cycles -> one run only; done_sig high from t+19 until start_sig falls, then IDLE. A second start pulse produces an identical second run.
- Reset mid-run: assert rst_n=0 at word 7 -> all outputs 0 asynchronously. The next start re-reads from addr 0 and the checksum restarts at 0.
- Start during READ: pulse start_sig at word 5 -> no effect; 16 words, single done_sig.
